// File: rtl/serializer_pattern_sequencer_pkg.sv
// Shared types and constants for the serializer pattern sequencer.
// Holds the controller state encoding and run-length sizing.
package serializer_ctrl_pkg;

    localparam int LOOP_W = 16;

    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SER_RST = 2'd1,
        PRIME   = 2'd2,
        PLAY    = 2'd3
    } state_e;

endpackage

// File: rtl/serializer_pattern_sequencer_if.sv
// Control/data bundle between a host and the pattern sequencer.
// The master drives RAM loads and run requests; the slave reports status.
interface serializer_if #(
    parameter int ADDR_W = 6
);
    import serializer_ctrl_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [LOOP_W-1:0] loop_count;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic              word_valid;
    logic [7:0]        parallel_out;
    logic              ser_rst;

    modport master (
        output wr_en, wr_addr, wr_data,
        output start_addr, end_addr, loop_count,
        output start, stop,
        input  busy, done, word_valid,
        input  parallel_out, ser_rst
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  start_addr, end_addr, loop_count,
        input  start, stop,
        output busy, done, word_valid,
        output parallel_out, ser_rst
    );

endinterface

// File: rtl/serializer_pattern_sequencer_ram.sv
// Simple dual-port pattern RAM, one-cycle synchronous read.
// A read and write to the same address in one cycle returns the old word.
module serializer_pattern_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rd_data_q;

    // Storage and read register share one edge, so reads see pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/serializer_pattern_sequencer.sv
// Pattern sequencer feeding an 8-bit OSERDES: resets the serializer,
// then replays a RAM address window for N passes (or until stopped).
module serializer_pattern_sequencer
    import serializer_ctrl_pkg::*;
#(
    parameter int         ADDR_W     = 6,
    parameter int         RST_CYCLES = 4,
    parameter logic [7:0] IDLE_WORD  = IDLE_WORD_DEFAULT
) (
    input  logic        slow_clock,
    input  logic        rst_n,
    serializer_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LOOP_W-1:0] pass_q, pass_d;
    logic              inf_q, inf_d;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              ser_rst_q, ser_rst_d;

    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              pass_end;
    logic              final_word;
    logic [7:0]        rd_data;

    serializer_pattern_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (slow_clock),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (issue_addr),
        .rd_data (rd_data)
    );

    // Pick the RAM address issued this cycle and classify it.
    always_comb begin
        issue      = 1'b0;
        issue_addr = addr_q;
        if (state_q == PRIME) begin
            issue      = 1'b1;
            issue_addr = start_q;
        end else if (state_q == PLAY && !last_q) begin
            issue = 1'b1;
        end
        pass_end   = (issue_addr == end_q);
        final_word = pass_end && !inf_q && (pass_q == 16'd1);
    end

    // Next-state, run bookkeeping and registered output decode.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        inf_d   = inf_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = SER_RST;
                    start_d = bus.start_addr;
                    end_d   = bus.end_addr;
                    pass_d  = bus.loop_count;
                    inf_d   = (bus.loop_count == '0);
                    last_d  = 1'b0;
                    cnt_d   = 8'(RST_CYCLES - 1);
                end
            end
            SER_RST: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = PRIME;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PRIME: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.stop || last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        if (issue && !bus.stop) begin
            addr_d = pass_end ? start_q : issue_addr + 1'b1;
            if (final_word) begin
                last_d = 1'b1;
            end else if (pass_end && !inf_q) begin
                pass_d = pass_q - 1'b1;
            end
        end

        ser_rst_d = (state_d == SER_RST);
        busy_d    = (state_d != IDLE);
        valid_d   = (state_d == PLAY);
    end

    // Controller state; reset holds the serializer in reset.
    always_ff @(posedge slow_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_q   <= '0;
            end_q     <= '0;
            addr_q    <= '0;
            pass_q    <= '0;
            inf_q     <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ser_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            addr_q    <= addr_d;
            pass_q    <= pass_d;
            inf_q     <= inf_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            ser_rst_q <= ser_rst_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.word_valid   = valid_q;
    assign bus.ser_rst      = ser_rst_q;
    assign bus.parallel_out = valid_q ? rd_data : IDLE_WORD;

endmodule

// File: tb/tb_serializer_pattern_sequencer.sv
// Bench for the serializer pattern sequencer: directed scenarios with
// literal expectations plus random traffic against a schedule model.
module tb_serializer_pattern_sequencer;

    localparam int         AW    = 6;
    localparam int         RC    = 4;
    localparam int         DEPTH = 64;
    localparam logic [7:0] IW    = 8'h00;

    logic slow_clock = 1'b0;
    logic rst_n      = 1'b0;

    serializer_if #(.ADDR_W(AW)) bus();

    serializer_pattern_sequencer #(
        .ADDR_W     (AW),
        .RST_CYCLES (RC),
        .IDLE_WORD  (IW)
    ) dut (
        .slow_clock (slow_clock),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is a schedule indexed by cycles since the
    // accepted start; word n of the run is window[n mod len].
    logic [7:0]    mmem [DEPTH];
    bit            act_run = 0;
    int            k = 0;
    int            m_len = 1;
    int            m_n = 0;
    int            m_start = 0;
    logic          e_busy = 0;
    logic          e_done = 0;
    logic          e_valid = 0;
    logic          e_rst = 1;
    logic [7:0]    e_word = IW;

    always @(posedge slow_clock or negedge rst_n) begin
        if (!rst_n) begin
            act_run = 0;
            e_busy  = 0;
            e_done  = 0;
            e_valid = 0;
            e_rst   = 1;
            e_word  = IW;
        end else begin
            e_done = 0;
            if (act_run) begin
                if (bus.stop || (m_n != 0 && k == RC + 1 + m_n)) begin
                    act_run = 0;
                    e_done  = 1;
                end
            end else if (bus.start && !bus.stop) begin
                act_run = 1;
                k       = 0;
                m_start = int'(bus.start_addr);
                m_len   = ((int'(bus.end_addr) - m_start + DEPTH) % DEPTH) + 1;
                m_n     = m_len * int'(bus.loop_count);
            end
            if (act_run) begin
                k++;
                e_busy  = 1;
                e_rst   = (k <= RC);
                e_valid = (k >= RC + 2);
                if (e_valid)
                    e_word = mmem[(m_start + (k - RC - 2) % m_len) % DEPTH];
                else
                    e_word = IW;
            end else begin
                e_busy  = 0;
                e_rst   = 0;
                e_valid = 0;
                e_word  = IW;
            end
            if (bus.wr_en) mmem[bus.wr_addr] = bus.wr_data;
        end
    end

    // Every cycle, compare all outputs with the model.
    always @(negedge slow_clock) begin
        chk("m_busy", 16'(bus.busy), 16'(e_busy));
        chk("m_done", 16'(bus.done), 16'(e_done));
        chk("m_valid", 16'(bus.word_valid), 16'(e_valid));
        chk("m_ser_rst", 16'(bus.ser_rst), 16'(e_rst));
        chk("m_word", 16'(bus.parallel_out), 16'(e_word));
    end

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        @(negedge slow_clock);
        bus.wr_en   = 1'b0;
    endtask

    task automatic go(input int sa, input int ea, input int lc);
        bus.start_addr = AW'(sa);
        bus.end_addr   = AW'(ea);
        bus.loop_count = 16'(lc);
        bus.start      = 1'b1;
        @(negedge slow_clock);
    endtask

    task automatic run_basic(input bit hold);
        logic [7:0] pat [4];
        bit         v;
        pat = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        go(0, 3, 2);
        if (!hold) bus.start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 12) bus.start = 1'b0;
            v = (i >= 6 && i <= 13);
            chk("b_ser_rst", 16'(bus.ser_rst), 16'(i <= RC));
            chk("b_valid", 16'(bus.word_valid), 16'(v));
            chk("b_word", 16'(bus.parallel_out),
                16'(v ? pat[(i - 6) % 4] : IW));
            chk("b_done", 16'(bus.done), 16'(i == 14));
            chk("b_busy", 16'(bus.busy), 16'(i <= 13));
            @(negedge slow_clock);
        end
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        bus.loop_count = '0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;

        repeat (2) @(negedge slow_clock);
        chk("rst_ser_rst", 16'(bus.ser_rst), 16'd1);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_word", 16'(bus.parallel_out), 16'(IW));
        rst_n = 1'b1;
        @(negedge slow_clock);
        chk("rel_ser_rst", 16'(bus.ser_rst), 16'd0);

        for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
        wr(0, 8'hA5);
        wr(1, 8'h3C);
        wr(2, 8'h0F);
        wr(3, 8'hF0);

        run_basic(1'b0);
        run_basic(1'b1);

        wr(62, 8'h11);
        wr(63, 8'h22);
        wr(0, 8'h33);
        go(62, 0, 1);
        bus.start = 1'b0;
        repeat (5) @(negedge slow_clock);
        chk("wrap_w0", 16'(bus.parallel_out), 16'h11);
        @(negedge slow_clock);
        chk("wrap_w1", 16'(bus.parallel_out), 16'h22);
        @(negedge slow_clock);
        chk("wrap_w2", 16'(bus.parallel_out), 16'h33);
        @(negedge slow_clock);
        chk("wrap_idle", 16'(bus.parallel_out), 16'(IW));
        chk("wrap_done", 16'(bus.done), 16'd1);
        wr(0, 8'hA5);

        wr(5, 8'h7E);
        go(5, 5, 0);
        bus.start = 1'b0;
        repeat (5) @(negedge slow_clock);
        for (int i = 0; i < 100; i++) begin
            chk("inf_word", 16'(bus.parallel_out), 16'h7E);
            @(negedge slow_clock);
        end
        bus.stop = 1'b1;
        @(negedge slow_clock);
        bus.stop = 1'b0;
        chk("inf_stop_done", 16'(bus.done), 16'd1);
        chk("inf_stop_busy", 16'(bus.busy), 16'd0);
        chk("inf_stop_word", 16'(bus.parallel_out), 16'(IW));

        bus.stop = 1'b1;
        go(0, 3, 1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss_busy", 16'(bus.busy), 16'd0);
        @(negedge slow_clock);
        chk("ss_ser_rst", 16'(bus.ser_rst), 16'd0);

        go(0, 3, 2);
        bus.start = 1'b0;
        repeat (7) @(negedge slow_clock);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_word", 16'(bus.parallel_out), 16'h00);
        chk("arst_ser_rst", 16'(bus.ser_rst), 16'd1);
        chk("arst_busy", 16'(bus.busy), 16'd0);
        @(negedge slow_clock);
        rst_n = 1'b1;
        @(negedge slow_clock);
        chk("arel_ser_rst", 16'(bus.ser_rst), 16'd0);
        chk("arel_done", 16'(bus.done), 16'd0);
        run_basic(1'b0);

        go(0, 3, 2);
        bus.start = 1'b0;
        repeat (6) @(negedge slow_clock);
        chk("rw_old", 16'(bus.parallel_out), 16'h3C);
        wr(1, 8'h99);
        repeat (3) @(negedge slow_clock);
        chk("rw_new", 16'(bus.parallel_out), 16'h99);
        repeat (3) @(negedge slow_clock);
        chk("rw_done", 16'(bus.done), 16'd1);
        wr(1, 8'h3C);

        for (int c = 0; c < 4000; c++) begin
            bus.start      = ($urandom % 8) == 0;
            bus.stop       = ($urandom % 32) == 0;
            bus.wr_en      = ($urandom % 4) == 0;
            bus.wr_addr    = AW'($urandom);
            bus.wr_data    = 8'($urandom);
            bus.start_addr = AW'($urandom);
            bus.end_addr   = AW'($urandom);
            bus.loop_count = 16'($urandom % 4);
            @(negedge slow_clock);
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.stop  = 1'b1;
        repeat (2) @(negedge slow_clock);
        bus.stop  = 1'b0;
        @(negedge slow_clock);
        chk("end_busy", 16'(bus.busy), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
